// File: rtl/nibble_serial_sub_if.sv
// Bundle for the nibble_serial_sub operand/result handshakes and the four_bits_sub stage link.
// The slave view belongs to the sequencer; the master view belongs to its environment.
interface nibble_serial_sub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bor_in;
  logic [3:0]       sub_a;
  logic [3:0]       sub_b;
  logic             sub_bor;
  logic [3:0]       sub_d;
  logic             sub_bor_out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bor_out;

  modport slave (
    input  in_valid, a, b, bor_in, sub_d, sub_bor_out, out_ready,
    output in_ready, sub_a, sub_b, sub_bor, out_valid, diff, bor_out
  );

  modport master (
    output in_valid, a, b, bor_in, sub_d, sub_bor_out, out_ready,
    input  in_ready, sub_a, sub_b, sub_bor, out_valid, diff, bor_out
  );
endinterface

// File: rtl/nibble_serial_sub.sv
// Multi-word subtractor sequencer: drives an external 4-bit subtract stage one nibble per clock,
// LSB first, chaining the borrow through a register.
module nibble_serial_sub #(
  parameter int unsigned WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  nibble_serial_sub_if.slave bus
);
  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : gen_width_check
    $error("nibble_serial_sub: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bor_q, bor_d;
  logic [CntW+1:0]  bit_idx;

  assign bit_idx = {cnt_q, 2'b00};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bor_d   = bor_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          bor_d   = bus.bor_in;
          cnt_d   = '0;
          diff_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        diff_d[bit_idx +: 4] = bus.sub_d;
        bor_d                = bus.sub_bor_out;
        if (cnt_q == CntW'(NIB - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bor_q   <= bor_d;
    end
  end

  // All outputs decode from registered state so the handshakes carry no input-to-output paths.
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.sub_a     = '0;
    bus.sub_b     = '0;
    bus.sub_bor   = 1'b0;
    bus.diff      = '0;
    bus.bor_out   = 1'b0;
    if (state_q == StRun) begin
      bus.sub_a   = a_q[bit_idx +: 4];
      bus.sub_b   = b_q[bit_idx +: 4];
      bus.sub_bor = bor_q;
    end
    if (state_q == StDone) begin
      bus.diff    = diff_q;
      bus.bor_out = bor_q;
    end
  end
endmodule

// File: tb/tb_nibble_serial_sub.sv
// Scoreboard bench for nibble_serial_sub with a behavioural four_bits_sub stage attached.
module tb_nibble_serial_sub;
  logic clk;
  logic rst_n;
  logic rand_ready;
  logic [4:0] stage_res;
  logic [16:0] exp_q[$];
  int n_pass;
  int n_total;

  nibble_serial_sub_if #(.WIDTH(16)) bus ();

  nibble_serial_sub #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Combinational four_bits_sub stage
  always_comb begin
    stage_res       = {1'b0, bus.sub_a} - {1'b0, bus.sub_b} - {4'b0, bus.sub_bor};
    bus.sub_d       = stage_res[3:0];
    bus.sub_bor_out = stage_res[4];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
  endtask

  // Random backpressure, applied late in the cycle so directed code owns out_ready when idle
  always begin
    @(posedge clk);
    #3;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on every result handshake
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("result", {15'b0, bus.bor_out, bus.diff}, {15'b0, e});
      end
    end
  end

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    int t;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.in_ready) check("accept_timeout", {31'b0, bus.in_ready}, 32'd1);
    bus.a        = av;
    bus.b        = bv;
    bus.bor_in   = bi;
    bus.in_valid = 1'b1;
    exp_q.push_back({1'b0, av} - {1'b0, bv} - {16'b0, bi});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = ~av;
    bus.b        = ~bv;
    bus.bor_in   = ~bi;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    check({tag, "_diff"}, {16'b0, bus.diff}, 32'd0);
    check({tag, "_bor_out"}, {31'b0, bus.bor_out}, 32'd0);
    check({tag, "_sub_ab"}, {24'b0, bus.sub_a, bus.sub_b}, 32'd0);
    check({tag, "_sub_bor"}, {31'b0, bus.sub_bor}, 32'd0);
  endtask

  initial begin
    logic [3:0] bo_exp;
    int t;
    n_pass        = 0;
    n_total       = 0;
    rand_ready    = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bor_in    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic transaction and latency
    send(16'h1234, 16'h0034, 1'b0);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("latency_low", {31'b0, bus.out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    check("latency_high", {31'b0, bus.out_valid}, 32'd1);
    check("t1_diff", {16'b0, bus.diff}, 32'h1200);
    @(posedge clk);
    #1;
    check("valid_one_cycle", {31'b0, bus.out_valid}, 32'd0);

    // 2: full borrow ripple
    send(16'h0000, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b1);
    drain();

    // 3: borrow chain visible on the stage link
    send(16'h1000, 16'h0000, 1'b1);
    bo_exp = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      check("t3_sub_bor", {31'b0, bus.sub_bor}, 32'd1);
      check("t3_stage_borrow", {31'b0, bus.sub_bor_out}, {31'b0, bo_exp[k]});
      @(posedge clk);
      #1;
    end
    check("t3_done_sub_bor", {31'b0, bus.sub_bor}, 32'd0);
    check("t3_done_sub_a", {28'b0, bus.sub_a}, 32'd0);
    drain();

    // 4: backpressure while in DONE, in_valid ignored
    bus.out_ready = 1'b0;
    send(16'h5A5A, 16'h1234, 1'b0);
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("t4_reach_done", {31'b0, bus.out_valid}, 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("t4_hold_valid", {31'b0, bus.out_valid}, 32'd1);
      check("t4_hold_diff", {15'b0, bus.bor_out, bus.diff}, 32'h04826);
      check("t4_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_release_valid", {31'b0, bus.out_valid}, 32'd0);
    check("t4_release_ready", {31'b0, bus.in_ready}, 32'd1);
    send(16'h1111, 16'h2222, 1'b0);
    drain();

    // 5: reset aborts a transaction mid-RUN
    send(16'h4321, 16'h1234, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check_idle_outputs("abort");
    repeat (2) begin
      @(posedge clk);
      #1;
      check("abort_no_valid", {31'b0, bus.out_valid}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_idle", {31'b0, bus.out_valid}, 32'd0);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    drain();

    // 6: random operands with random result stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    rand_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
